error_calc: RTL and testbench

ERROR_CALC -- requirements
Module: error_calc

---
 rtl/error_calc_pkg.sv | 22 ++
 rtl/error_calc_cu.sv | 88 ++++++++
 rtl/error_calc_dp.sv | 93 +++++++++
 rtl/error_calc.sv | 66 ++++++
 tb/tb_error_calc.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/error_calc_pkg.sv
// Shared regression definitions: fixed-point format, accumulator width and
// the error-stage sequencing states.
package error_calc_pkg;

    localparam int REG_W    = 20;
    localparam int REG_FRAC = 10;
    localparam int SSE_W    = 48;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } ec_state_e;

    function automatic logic [SSE_W-1:0] sat_add(input logic [SSE_W-1:0] a,
                                                 input logic [SSE_W-1:0] b);
        logic [SSE_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[SSE_W] ? '1 : sum[SSE_W-1:0];
    endfunction

endpackage

// File: rtl/error_calc_cu.sv
// Error-stage control: run sequencing, sample counter and pipeline valid strobes.
//   state    | meaning
//   ST_IDLE  | waiting for En; results from the last run held
//   ST_RUN   | accepting samples until N_SAMPLES have been taken
//   ST_DRAIN | no more samples; waiting for the pipeline to empty
module error_calc_cu
    import error_calc_pkg::*;
#(
    parameter int N_SAMPLES = 150
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic in_valid,
    output logic in_ready,
    output logic load,
    output logic accept,
    output logic s1_valid,
    output logic err_valid,
    output logic busy,
    output logic done
);

    localparam int CNT_W = $clog2(N_SAMPLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(N_SAMPLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_SAMPLES - 1);

    ec_state_e        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             s1_valid_q, s1_valid_d;
    logic             err_valid_q, err_valid_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            s1_valid_q  <= 1'b0;
            err_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            s1_valid_q  <= s1_valid_d;
            err_valid_q <= err_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        load        = 1'b0;
        done        = 1'b0;
        in_ready    = (state_q == ST_RUN) && (count_q < CNT_MAX);
        accept      = in_ready && in_valid;
        s1_valid_d  = accept;
        err_valid_d = s1_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    load    = 1'b1;
                    count_d = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept) begin
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_LAST) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // the accumulate happens on the edge that clears err_valid
                if (!s1_valid_q && !err_valid_q) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign s1_valid  = s1_valid_q;
    assign err_valid = err_valid_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: rtl/error_calc_dp.sv
// Error-stage datapath: coefficient latch, product stage, prediction/error
// stage and saturating sum-of-squares accumulator.
module error_calc_dp
    import error_calc_pkg::*;
#(
    parameter int W    = REG_W,
    parameter int FRAC = REG_FRAC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             accept,
    input  logic             s1_valid,
    input  logic             err_valid,
    input  logic [W-1:0]     b0_in,
    input  logic [W-1:0]     b1_in,
    input  logic [W-1:0]     x,
    input  logic [W-1:0]     y,
    output logic [W-1:0]     yhat,
    output logic [W-1:0]     err,
    output logic [SSE_W-1:0] sse
);

    localparam int PW = 2 * W;

    logic [W-1:0]          b0_q, b0_d, b1_q, b1_d;
    logic signed [PW-1:0]  prod_q, prod_d;
    logic [W-1:0]          y1_q, y1_d;
    logic [W-1:0]          yhat_q, yhat_d, err_q, err_d;
    logic [SSE_W-1:0]      sse_q, sse_d;
    logic signed [PW-1:0]  b1_ext, x_ext, err_ext, sq;
    logic                  prod_unused;

    always_ff @(posedge clk) begin
        if (rst) begin
            b0_q   <= '0;
            b1_q   <= '0;
            prod_q <= '0;
            y1_q   <= '0;
            yhat_q <= '0;
            err_q  <= '0;
            sse_q  <= '0;
        end else begin
            b0_q   <= b0_d;
            b1_q   <= b1_d;
            prod_q <= prod_d;
            y1_q   <= y1_d;
            yhat_q <= yhat_d;
            err_q  <= err_d;
            sse_q  <= sse_d;
        end
    end

    always_comb begin
        b0_d    = b0_q;
        b1_d    = b1_q;
        prod_d  = prod_q;
        y1_d    = y1_q;
        yhat_d  = yhat_q;
        err_d   = err_q;
        sse_d   = sse_q;
        b1_ext  = PW'($signed(b1_q));
        x_ext   = PW'($signed(x));
        err_ext = PW'($signed(err_q));
        sq      = err_ext * err_ext;

        if (load) begin
            b0_d = b0_in;
            b1_d = b1_in;
        end
        if (accept) begin
            prod_d = b1_ext * x_ext;
            y1_d   = y;
        end
        if (s1_valid) begin
            yhat_d = b0_q + prod_q[W+FRAC-1:FRAC];
            err_d  = y1_q - yhat_d;
        end
        if (load) begin
            sse_d = '0;
        end else if (err_valid) begin
            sse_d = sat_add(sse_q, {{(SSE_W-PW){1'b0}}, sq});
        end
    end

    // only the Q10.10 window of the product feeds the prediction
    assign prod_unused = ^{prod_q[PW-1:W+FRAC], prod_q[FRAC-1:0]};

    assign yhat = yhat_q;
    assign err  = err_q;
    assign sse  = sse_q;

endmodule

// File: rtl/error_calc.sv
// Regression error stage: predicts yhat = B0 + B1*x per sample, reports the
// residual and accumulates the sum of squared residuals over a run.
module error_calc
    import error_calc_pkg::*;
#(
    parameter int N_SAMPLES = 150,
    parameter int W         = REG_W,
    parameter int FRAC      = REG_FRAC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             En,
    input  logic [W-1:0]     B0,
    input  logic [W-1:0]     B1,
    input  logic [W-1:0]     x,
    input  logic [W-1:0]     y,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [W-1:0]     yhat,
    output logic [W-1:0]     err,
    output logic             err_valid,
    output logic [SSE_W-1:0] sse,
    output logic             busy,
    output logic             done
);

    logic load;
    logic accept;
    logic s1_valid;

    error_calc_cu #(
        .N_SAMPLES (N_SAMPLES)
    ) u_cu (
        .clk       (clk),
        .rst       (rst),
        .en        (En),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .load      (load),
        .accept    (accept),
        .s1_valid  (s1_valid),
        .err_valid (err_valid),
        .busy      (busy),
        .done      (done)
    );

    error_calc_dp #(
        .W    (W),
        .FRAC (FRAC)
    ) u_dp (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .accept    (accept),
        .s1_valid  (s1_valid),
        .err_valid (err_valid),
        .b0_in     (B0),
        .b1_in     (B1),
        .x         (x),
        .y         (y),
        .yhat      (yhat),
        .err       (err),
        .sse       (sse)
    );

endmodule

// File: tb/tb_error_calc.sv
// Scoreboard bench for error_calc: random runs checked against a plain
// arithmetic model of the prediction, residual and sum of squares.
module tb_error_calc;

    localparam int NS   = 4;
    localparam int W    = 20;
    localparam int FRAC = 10;
    localparam longint SSE_MAX = (64'd1 << 48) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         En = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] B0 = '0, B1 = '0, x = '0, y = '0;
    logic         in_ready, err_valid, busy, done;
    logic [W-1:0] yhat, err;
    logic [47:0]  sse;

    error_calc #(.N_SAMPLES(NS), .W(W), .FRAC(FRAC)) dut (
        .clk(clk), .rst(rst), .En(En), .B0(B0), .B1(B1), .x(x), .y(y),
        .in_valid(in_valid), .in_ready(in_ready), .yhat(yhat), .err(err),
        .err_valid(err_valid), .sse(sse), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct { logic [W-1:0] yh; logic [W-1:0] e; int due; } exp_t;
    typedef struct { longint s; int due; } done_t;
    exp_t  exp_q[$];
    done_t done_q[$];
    exp_t  mon_e;
    done_t mon_d;

    logic [W-1:0] m_b0, m_b1, last_yh, last_e;
    longint       m_sse;
    int           m_acc;
    logic [W-1:0] sx[NS], sy[NS];
    int           sg[NS];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_msg(input string name, input string detail);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s (cycle %0d)", name, detail, cyc);
    endtask

    function automatic void ref_model(input logic [W-1:0] b0, input logic [W-1:0] b1,
                                      input logic [W-1:0] xv, input logic [W-1:0] yv,
                                      output logic [W-1:0] yh, output logic [W-1:0] e,
                                      output longint sq);
        longint p, se;
        p  = longint'($signed(b1)) * longint'($signed(xv));
        yh = W'(longint'($signed(b0)) + (p >>> FRAC));
        e  = W'(longint'($signed(yv)) - longint'($signed(yh)));
        se = longint'($signed(e));
        sq = se * se;
    endfunction

    // monitor: pops expectations whenever the DUT presents a result
    always @(negedge clk) begin
        if (!rst) begin
            if (err_valid) begin
                if (exp_q.size() == 0) begin
                    fail_msg("err_valid_unexpected", "got err_valid=1 required 0");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("err_valid_latency", 64'(cyc), 64'(mon_e.due));
                    check("yhat", 64'(yhat), 64'(mon_e.yh));
                    check("err", 64'(err), 64'(mon_e.e));
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                mon_e = exp_q.pop_front();
                fail_msg("err_valid_missing", $sformatf("got err_valid=0 required 1 at cycle %0d", mon_e.due));
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    fail_msg("done_unexpected", "got done=1 required 0");
                end else begin
                    mon_d = done_q.pop_front();
                    check("done_latency", 64'(cyc), 64'(mon_d.due));
                    check("sse_at_done", 64'(sse), 64'(mon_d.s));
                end
            end else if (done_q.size() > 0 && done_q[0].due <= cyc) begin
                mon_d = done_q.pop_front();
                fail_msg("done_missing", $sformatf("got done=0 required 1 at cycle %0d", mon_d.due));
            end
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
        check({tag, "_err_valid"}, 64'(err_valid), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_yhat"}, 64'(yhat), 64'd0);
        check({tag, "_err"}, 64'(err), 64'd0);
        check({tag, "_sse"}, 64'(sse), 64'd0);
    endtask

    task automatic start_run(input logic [W-1:0] b0, input logic [W-1:0] b1);
        En = 1'b1; B0 = b0; B1 = b1;
        m_b0 = b0; m_b1 = b1; m_sse = 0; m_acc = 0;
        @(negedge clk);
        En = 1'b0; B0 = W'($urandom); B1 = W'($urandom);
        check("busy_after_en", 64'(busy), 64'd1);
        check("sse_cleared_on_en", 64'(sse), 64'd0);
    endtask

    task automatic feed(input logic [W-1:0] xv, input logic [W-1:0] yv);
        logic [W-1:0] yh, e;
        longint sq;
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1; x = xv; y = yv;
        for (int t = 0; t < 20 && !ok; t++) begin
            if (in_ready) begin
                ref_model(m_b0, m_b1, xv, yv, yh, e, sq);
                exp_q.push_back('{yh, e, cyc + 2});
                m_sse = (m_sse + sq > SSE_MAX) ? SSE_MAX : m_sse + sq;
                m_acc++;
                last_yh = yh; last_e = e;
                if (m_acc == NS) done_q.push_back('{m_sse, cyc + 3});
                ok = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0; x = W'($urandom); y = W'($urandom);
        if (!ok) fail_msg("accept_timeout", "got in_ready=0 for 20 cycles required 1");
    endtask

    task automatic do_run(input logic [W-1:0] b0, input logic [W-1:0] b1,
                          input int en_busy_after, input int rst_after);
        start_run(b0, b1);
        for (int i = 0; i < NS; i++) begin
            feed(sx[i], sy[i]);
            if (i + 1 == rst_after) begin
                rst = 1'b1; En = 1'b1; B0 = W'($urandom); B1 = W'($urandom);
                @(negedge clk);
                En = 1'b0;
                exp_q.delete();
                done_q.delete();
                check_reset_state("midrun_reset");
                rst = 1'b0;
                return;
            end
            if (i + 1 == en_busy_after) begin
                En = 1'b1; B0 = ~m_b0; B1 = m_b1 ^ 20'h00C01;
                @(negedge clk);
                En = 1'b0;
                check("busy_during_ignored_en", 64'(busy), 64'd1);
            end
            repeat (sg[i]) @(negedge clk);
        end
        for (int t = 0; t < 20 && busy; t++) begin
            check("in_ready_low_after_last", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        check("busy_cleared", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        check("hold_in_ready", 64'(in_ready), 64'd0);
        check("hold_yhat", 64'(yhat), 64'(last_yh));
        check("hold_err", 64'(err), 64'(last_e));
        check("hold_sse", 64'(sse), 64'(m_sse));
    endtask

    task automatic randomize_samples();
        for (int i = 0; i < NS; i++) begin
            sx[i] = W'($urandom);
            sy[i] = W'($urandom);
            sg[i] = int'($urandom_range(0, 2));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        // known-value run with stalls after samples 1 and 3
        randomize_samples();
        sx[0] = 20'h00C00; sy[0] = 20'h01C00;
        sx[1] = 20'h00C00; sy[1] = 20'h02000;
        sg[0] = 2; sg[1] = 0; sg[2] = 1; sg[3] = 0;
        do_run(20'h00400, 20'h00800, 0, 0);

        randomize_samples();
        sx[0] = 20'h00800; sy[0] = 20'h00000;
        do_run(20'h00000, 20'hFFC00, 0, 0);

        randomize_samples();
        do_run(W'($urandom), W'($urandom), 2, 0);

        randomize_samples();
        do_run(W'($urandom), W'($urandom), 0, 2);
        repeat (2) @(negedge clk);
        check_reset_state("after_reset_idle");

        randomize_samples();
        do_run(W'($urandom), W'($urandom), 0, 0);

        for (int r = 0; r < 20; r++) begin
            randomize_samples();
            do_run(W'($urandom), W'($urandom), (r % 5 == 0) ? 3 : 0, 0);
        end

        repeat (4) @(negedge clk);
        check("leftover_err_expectations", 64'(exp_q.size()), 64'd0);
        check("leftover_done_expectations", 64'(done_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
